// File: rtl/eh2_dec_gpr_bank.sv
// Multi-thread decode-stage integer register file: NRD read / NWR write ports,
// same-cycle bypass, write-collision flag, per-thread clear sequencer.
// Optional parity storage and injection under `GPR_PARITY_EN.
module eh2_dec_gpr_bank #(
    parameter int unsigned NUM_THREADS = 2,
    parameter int unsigned NRD         = 4,
    parameter int unsigned NWR         = 4,
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BYPASS      = 1,
    localparam int unsigned TW         = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [NRD*5-1:0]    raddr,
    input  logic [NRD*TW-1:0]   rtid,
    input  logic [NRD-1:0]      rden,
    output logic [NRD*XLEN-1:0] rd,
    input  logic [NWR*5-1:0]    waddr,
    input  logic [NWR*TW-1:0]   wtid,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic                clr_req,
    input  logic [TW-1:0]       clr_tid,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                wr_collision,
    input  logic                scan_mode
`ifdef GPR_PARITY_EN
    ,
    input  logic [NWR-1:0]      par_inj,
    output logic [NRD-1:0]      rd_perr
`endif
);

    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} clr_state_e;

    clr_state_e          r_state;
    logic [AW-1:0]       r_cnt;
    logic [TW-1:0]       r_ctid;
    logic                r_clr_busy;
    logic                r_clr_done;
    logic                r_wr_collision;

    logic [XLEN-1:0]     r_bank [NUM_THREADS][NREG];
    logic                w_we   [NUM_THREADS][NREG];
    logic [XLEN-1:0]     w_wd   [NUM_THREADS][NREG];
    logic [NWR-1:0]      w_port_ok;
    logic                w_collision;
    logic [NRD-1:0]      w_byp;
`ifdef GPR_PARITY_EN
    logic                r_par  [NUM_THREADS][NREG];
    logic                w_wp   [NUM_THREADS][NREG];
`endif

    // Clock-gating test enable has no functional effect on this model.
    logic w_unused_scan;
    assign w_unused_scan = scan_mode;

    // A thread id is usable only when it selects an implemented bank.
    function automatic logic tid_ok(input logic [TW-1:0] tid);
        return ({1'b0, tid} < (TW+1)'(NUM_THREADS));
    endfunction

    assign clr_busy     = r_clr_busy;
    assign clr_done     = r_clr_done;
    assign wr_collision = r_wr_collision;

    // Port qualification: x0 and out-of-range threads never write.
    always_comb begin
        w_port_ok = '0;
        for (int p = 0; p < int'(NWR); p++) begin
            w_port_ok[p] = wen[p] && (waddr[p*AW +: AW] != '0) && tid_ok(wtid[p*TW +: TW]);
        end
    end

    always_comb begin
        w_collision = 1'b0;
        for (int p = 0; p < int'(NWR); p++) begin
            for (int q = p + 1; q < int'(NWR); q++) begin
                if (w_port_ok[p] && w_port_ok[q] &&
                    (waddr[p*AW +: AW] == waddr[q*AW +: AW]) &&
                    (wtid[p*TW +: TW] == wtid[q*TW +: TW])) begin
                    w_collision = 1'b1;
                end
            end
        end
    end

    // Clear write first, then ports high-to-low so the lowest port lands last.
    always_comb begin
        for (int t = 0; t < int'(NUM_THREADS); t++) begin
            for (int a = 0; a < int'(NREG); a++) begin
                w_we[t][a] = 1'b0;
                w_wd[t][a] = '0;
`ifdef GPR_PARITY_EN
                w_wp[t][a] = 1'b0;
`endif
            end
        end
        if ((r_state == ST_CLEAR) && tid_ok(r_ctid)) begin
            w_we[r_ctid][r_cnt] = 1'b1;
        end
        for (int p = int'(NWR) - 1; p >= 0; p--) begin
            if (w_port_ok[p]) begin
                w_we[wtid[p*TW +: TW]][waddr[p*AW +: AW]] = 1'b1;
                w_wd[wtid[p*TW +: TW]][waddr[p*AW +: AW]] = wd[p*XLEN +: XLEN];
`ifdef GPR_PARITY_EN
                w_wp[wtid[p*TW +: TW]][waddr[p*AW +: AW]] = (^wd[p*XLEN +: XLEN]) ^ par_inj[p];
`endif
            end
        end
    end

    // Enable-gated register storage.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int t = 0; t < int'(NUM_THREADS); t++) begin
                for (int a = 0; a < int'(NREG); a++) begin
                    r_bank[t][a] <= '0;
`ifdef GPR_PARITY_EN
                    r_par[t][a]  <= 1'b0;
`endif
                end
            end
        end else begin
            for (int t = 0; t < int'(NUM_THREADS); t++) begin
                for (int a = 1; a < int'(NREG); a++) begin
                    if (w_we[t][a]) begin
                        r_bank[t][a] <= w_wd[t][a];
`ifdef GPR_PARITY_EN
                        r_par[t][a]  <= w_wp[t][a];
`endif
                    end
                end
            end
        end
    end

    // Read path with optional bypass from the winning same-cycle port write.
    always_comb begin
        rd    = '0;
        w_byp = '0;
`ifdef GPR_PARITY_EN
        rd_perr = '0;
`endif
        for (int i = 0; i < int'(NRD); i++) begin
            if (rden[i] && (raddr[i*AW +: AW] != '0) && tid_ok(rtid[i*TW +: TW])) begin
                rd[i*XLEN +: XLEN] = r_bank[rtid[i*TW +: TW]][raddr[i*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int p = int'(NWR) - 1; p >= 0; p--) begin
                        if (w_port_ok[p] &&
                            (waddr[p*AW +: AW] == raddr[i*AW +: AW]) &&
                            (wtid[p*TW +: TW] == rtid[i*TW +: TW])) begin
                            rd[i*XLEN +: XLEN] = wd[p*XLEN +: XLEN];
                            w_byp[i]           = 1'b1;
                        end
                    end
                end
`ifdef GPR_PARITY_EN
                rd_perr[i] = !w_byp[i] &&
                    (r_par[rtid[i*TW +: TW]][raddr[i*AW +: AW]] !=
                     ^r_bank[rtid[i*TW +: TW]][raddr[i*AW +: AW]]);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_collision <= 1'b0;
        end else begin
            r_wr_collision <= w_collision;
        end
    end

    // Clear sequencer: walks x1..x31 of the latched thread, then pulses done.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ctid     <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_clr_done <= 1'b0;
                    if (clr_req) begin
                        r_state    <= ST_CLEAR;
                        r_ctid     <= clr_tid;
                        r_cnt      <= AW'(1);
                        r_clr_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_cnt <= r_cnt + AW'(1);
                    if (r_cnt == AW'(31)) begin
                        r_state    <= ST_DONE;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_clr_done <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eh2_dec_gpr_bank.sv
// Directed self-checking bench for eh2_dec_gpr_bank (2 threads, 4R/4W, bypass on).
// Parity checks are compiled in only with `GPR_PARITY_EN.
module tb_eh2_dec_gpr_bank;

    localparam int unsigned NT = 2;
    localparam int unsigned NR = 4;
    localparam int unsigned NW = 4;
    localparam int unsigned XL = 32;
    localparam int unsigned TW = 1;

    logic             clk;
    logic             rst_l;
    logic [NR*5-1:0]  raddr;
    logic [NR*TW-1:0] rtid;
    logic [NR-1:0]    rden;
    logic [NR*XL-1:0] rd;
    logic [NW*5-1:0]  waddr;
    logic [NW*TW-1:0] wtid;
    logic [NW-1:0]    wen;
    logic [NW*XL-1:0] wd;
    logic             clr_req;
    logic [TW-1:0]    clr_tid;
    logic             clr_busy;
    logic             clr_done;
    logic             wr_collision;
    logic             scan_mode;
`ifdef GPR_PARITY_EN
    logic [NW-1:0]    par_inj;
    logic [NR-1:0]    rd_perr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    eh2_dec_gpr_bank #(
        .NUM_THREADS(NT), .NRD(NR), .NWR(NW), .XLEN(XL), .BYPASS(1)
    ) u_dut (
        .clk(clk), .rst_l(rst_l),
        .raddr(raddr), .rtid(rtid), .rden(rden), .rd(rd),
        .waddr(waddr), .wtid(wtid), .wen(wen), .wd(wd),
        .clr_req(clr_req), .clr_tid(clr_tid),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .wr_collision(wr_collision), .scan_mode(scan_mode)
`ifdef GPR_PARITY_EN
        , .par_inj(par_inj), .rd_perr(rd_perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input int tid, input int addr, input logic [31:0] data);
        wen[p]           = 1'b1;
        wtid[p*TW +: TW] = TW'(tid);
        waddr[p*5 +: 5]  = 5'(addr);
        wd[p*XL +: XL]   = data;
    endtask

    task automatic rdp(input int p, input int tid, input int addr);
        rden[p]          = 1'b1;
        rtid[p*TW +: TW] = TW'(tid);
        raddr[p*5 +: 5]  = 5'(addr);
    endtask

    function automatic logic [31:0] rdv(input int p);
        return rd[p*XL +: XL];
    endfunction

    task automatic read_all_zero(input string tag);
        for (int t = 0; t < int'(NT); t++) begin
            for (int a = 1; a < 32; a++) begin
                for (int p = 0; p < int'(NR); p++) rdp(p, t, a);
                #1;
                for (int p = 0; p < int'(NR); p++) chk(tag, rdv(p), 32'h0);
            end
        end
        rden = '0;
    endtask

    initial begin
        rst_l = 1'b0; raddr = '0; rtid = '0; rden = '0;
        waddr = '0; wtid = '0; wen = '0; wd = '0;
        clr_req = 1'b0; clr_tid = '0; scan_mode = 1'b0;
`ifdef GPR_PARITY_EN
        par_inj = '0;
`endif
        step(); step();
        chk("rst_busy", 32'(clr_busy), 32'd0);
        chk("rst_done", 32'(clr_done), 32'd0);
        chk("rst_coll", 32'(wr_collision), 32'd0);
        rst_l = 1'b1;
        step();
        read_all_zero("rst_rd");

        // Basic write/read, plus a discarded x0 write on port 3.
        wr(0, 1, 5, 32'hDEADBEEF);
        wr(3, 1, 0, 32'hFFFF0000);
        step();
        wen = '0;
        rdp(0, 1, 5); rdp(1, 0, 5); rdp(3, 1, 0);
        rtid[2*TW +: TW] = 1'b1; raddr[2*5 +: 5] = 5'd5; rden[2] = 1'b0;
        #1;
        chk("wr_t1x5", rdv(0), 32'hDEADBEEF);
        chk("wr_t0x5", rdv(1), 32'h0);
        chk("rden_off", rdv(2), 32'h0);
        chk("x0_rd", rdv(3), 32'h0);
        chk("x0_nocoll", 32'(wr_collision), 32'd0);
        rden = '0;

        // Collision on tid0 x7: port 0 wins, bypassed same-cycle read.
        wr(0, 0, 7, 32'h11);
        wr(2, 0, 7, 32'h22);
        rdp(0, 0, 7);
        #1;
        chk("byp_x7", rdv(0), 32'h11);
        chk("coll_pre", 32'(wr_collision), 32'd0);
        step();
        wen = '0;
        #1;
        chk("coll_set", 32'(wr_collision), 32'd1);
        chk("coll_x7", rdv(0), 32'h11);
        rden = '0;
        wr(0, 0, 0, 32'h1); wr(1, 0, 0, 32'h2);
        step();
        wen = '0;
        chk("coll_clr", 32'(wr_collision), 32'd0);
        step();
        chk("x0_coll", 32'(wr_collision), 32'd0);

        // Fill tid0, mark tid1 x12.
        for (int j = 1; j < 32; j++) begin
            wr(0, 0, j, 32'hA5A5A5A0 + 32'(j));
            step();
        end
        wr(0, 1, 12, 32'h1234);
        step();
        wen = '0;
        rdp(0, 0, 31); #1;
        chk("fill_x31", rdv(0), 32'hA5A5A5BF);
        rden = '0;

        // Clear tid0: clr_req sampled at the edge that opens cycle T+1.
        clr_req = 1'b1; clr_tid = 1'b0;
        step();
        clr_req = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            chk($sformatf("busy_k%0d", k), 32'(clr_busy), 32'(k <= 31));
            chk($sformatf("done_k%0d", k), 32'(clr_done), 32'(k == 32));
            if (k == 5)  begin clr_req = 1'b1; clr_tid = 1'b1; end
            if (k == 6)  clr_req = 1'b0;
            if (k == 32) begin clr_req = 1'b1; clr_tid = 1'b1; end
            if (k == 33) clr_req = 1'b0;
            if (k == 10) begin
                wr(0, 0, 3, 32'h55); wr(1, 0, 20, 32'h66); wr(2, 0, 10, 32'h77);
                rdp(3, 0, 25); rdp(2, 0, 5);
                #1;
                chk("mid_x25", rdv(3), 32'hA5A5A5B9);
                chk("mid_x5", rdv(2), 32'h0);
            end
            if (k == 11) begin wen = '0; rden = '0; end
            step();
        end
        rdp(0, 0, 3); rdp(1, 0, 10); rdp(2, 0, 20); rdp(3, 0, 31); #1;
        chk("clr_x3", rdv(0), 32'h55);
        chk("clr_x10", rdv(1), 32'h77);
        chk("clr_x20", rdv(2), 32'h0);
        chk("clr_x31", rdv(3), 32'h0);
        rdp(0, 0, 1); rdp(1, 1, 5); rdp(2, 1, 12); rdp(3, 0, 7); #1;
        chk("clr_x1", rdv(0), 32'h0);
        chk("t1_x5", rdv(1), 32'hDEADBEEF);
        chk("t1_x12", rdv(2), 32'h1234);
        chk("clr_x7", rdv(3), 32'h0);
        rden = '0;

        // Reset in the middle of a tid1 clear.
        clr_req = 1'b1; clr_tid = 1'b1;
        step();
        clr_req = 1'b0;
        chk("rc_busy", 32'(clr_busy), 32'd1);
        repeat (14) step();
        rst_l = 1'b0;
        #1;
        chk("rc_busy0", 32'(clr_busy), 32'd0);
        chk("rc_done0", 32'(clr_done), 32'd0);
        step();
        rst_l = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            chk($sformatf("rc_nodone%0d", k), 32'(clr_done), 32'd0);
        end
        chk("rc_busy_end", 32'(clr_busy), 32'd0);
        read_all_zero("rc_rd");

`ifdef GPR_PARITY_EN
        wr(0, 0, 9, 32'h1); par_inj[0] = 1'b1;
        step();
        wen = '0; par_inj = '0;
        rdp(0, 0, 9); #1;
        chk("par_data", rdv(0), 32'h1);
        chk("par_err1", 32'(rd_perr[0]), 32'd1);
        wr(1, 0, 9, 32'h1);
        #1;
        chk("par_byp", 32'(rd_perr[0]), 32'd0);
        step();
        wen = '0;
        #1;
        chk("par_err0", 32'(rd_perr[0]), 32'd0);
        rden = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eh2_dec_gpr_bank.md
Name: eh2_dec_gpr_bank

Overview:
Parametrised multi-thread integer register file for the decode stage.
- Generalises the fixed 4R/4W, single-thread-select GPR array to N threads, NRD read ports and NWR write ports.
- Adds same-cycle write-to-read bypass, priority write-collision resolution with a registered collision flag, and a per-thread hardware clear sequencer.
- Sits between the decode read stage and the writeback/commit ports.

Parameters:
NUM_THREADS, 2, hardware threads; one bank of x1..x31 per thread.
NRD, 4, read ports.
NWR, 4, write ports.
XLEN, 32, register width.
BYPASS, 1, 1 = a read sees same-cycle write data; 0 = a read sees stored value only.
TW (localparam), max(1,$clog2(NUM_THREADS)), thread-id width.

Ports:
clk  in  1  core clock
rst_l  in  1  asynchronous active-low reset
raddr  in  NRD*5  read addresses; port i at [5i+4:5i]
rtid  in  NRD*TW  read thread ids
rden  in  NRD  read enables
rd  out  NRD*XLEN  read data
waddr  in  NWR*5  write addresses
wtid  in  NWR*TW  write thread ids
wen  in  NWR  write enables
wd  in  NWR*XLEN  write data
clr_req  in  1  single-cycle request to zero one thread's bank
clr_tid  in  TW  thread to clear
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse when a clear completes
wr_collision  out  1  registered: two or more enabled ports targeted the same tid/addr last cycle
scan_mode  in  1  scan enable, passed to clock gating

Behaviour:
- Clocking/reset: single clock clk; reset rst_l is asynchronous and active-low.
- Reset: all registers in all banks = 0; clr_busy = 0, clr_done = 0, wr_collision = 0; FSM = IDLE.
- x0: reads return 0 regardless of tid; writes to addr 0 are discarded and never count toward a collision.
- Reads are combinational.
  - rd[i] = 0 when rden[i] = 0 or raddr[i] = 0.
  - Otherwise rd[i] = bank[rtid[i]][raddr[i]].
  - BYPASS=1: an enabled write this cycle to the same tid/addr (the winner after priority) is returned instead.
- Writes take effect on the next rising edge. Each register uses an enable-gated flop; its enable is active only when some port or the clear sequencer writes it.
- Write collision: when several enabled ports hit the same tid/addr, the lowest-numbered port wins. wr_collision = 1 in the following cycle only.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_req: latch clr_tid, set 5-bit counter cnt = 1, clr_busy = 1 from the next cycle.
  - CLEAR: each cycle write 0 to bank[ctid][cnt], then cnt++. After cnt = 31 is written -> DONE.
  - DONE: clr_done = 1 for one cycle, clr_busy = 0 -> IDLE.
  - Total: clr_req at cycle T gives clr_busy high for T+1..T+31 and clr_done high at T+32.
- Clear vs port write: a port write to bank[ctid][cnt] in the same cycle wins over the clear write.
  - Port writes to already-cleared registers (index < cnt) persist.
  - Writes to not-yet-cleared registers are zeroed later by the sequencer.
- clr_req while clr_busy = 1 or in DONE: ignored, no queueing.
- Reads of ctid during CLEAR return current contents (partially cleared). Software must wait for clr_done.
- rst_l asserted mid-clear: FSM -> IDLE immediately, all banks zero, clr_done is not pulsed.
- Out-of-range tid (tid >= NUM_THREADS, only possible when NUM_THREADS is not a power of 2): reads return 0, writes are discarded.

Optional Feature:
GPR_PARITY_EN
- Defined: each register stores one extra even-parity bit computed from the write data; the clear sequencer writes parity 0.
  - Adds output rd_perr[NRD]: combinational, 1 when rden[i], raddr[i] != 0, the value is not bypassed, and stored parity != ^data.
  - Adds input par_inj[NWR]: when set with wen, the stored parity bit is inverted, for error injection.
- Undefined: no parity storage; rd_perr and par_inj do not exist.

Test Plan:
- Reset, then read all 31 addrs on every port for tid0 and tid1 -> all rd = 0; clr_busy = wr_collision = 0.
- wen0: tid1 x5 = 0xDEADBEEF; next cycle rden0 tid1 x5 -> 0xDEADBEEF; rden1 tid0 x5 -> 0.
- Same cycle: wen0 x7 = 0x11 and wen2 x7 = 0x22 (tid0) -> x7 = 0x11; wr_collision = 1 for exactly one cycle. With BYPASS=1, a same-cycle read of x7 returns 0x11.
- Fill tid0 x1..x31 with 0xA5A5A5A0+j; clr_req tid0 at T.
  - clr_busy high T+1..T+31; clr_done pulse at T+32.
  - Port write x3 = 0x55 at T+10 persists; x20 written at T+10 reads 0 after done; tid1 untouched.
- Assert rst_l low at T+15 of a clear -> clr_busy = 0 immediately, no clr_done, all registers 0.
- (GPR_PARITY_EN) write x9 = 0x1 with par_inj = 1 -> read x9 gives rd_perr = 1; rewrite without par_inj -> rd_perr = 0.
